// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt-controller command sequencer.
// Holds the init FSM state encoding, OCW2 command codes and command-byte bit positions.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    // OCW2 {R, SL, EOI} codes
    localparam logic [2:0] OCW2_RAEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NSEOI     = 3'b001;
    localparam logic [2:0] OCW2_NOP       = 3'b010;
    localparam logic [2:0] OCW2_SEOI      = 3'b011;
    localparam logic [2:0] OCW2_RAEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NSEOI = 3'b101;
    localparam logic [2:0] OCW2_SETPRIO   = 3'b110;
    localparam logic [2:0] OCW2_ROT_SEOI  = 3'b111;

    localparam int ICW1_IC4_BIT   = 0;
    localparam int ICW1_SNGL_BIT  = 1;
    localparam int ICW1_LTIM_BIT  = 3;
    localparam int ICW1_SEL_BIT   = 4;
    localparam int ICW4_AEOI_BIT  = 1;
    localparam int OCW3_SEL_BIT   = 3;
    localparam int OCW3_RIS_BIT   = 0;
    localparam int OCW3_RR_BIT    = 1;
    localparam int OCW3_P_BIT     = 2;
    localparam int OCW3_SMM_BIT   = 5;
    localparam int OCW3_ESMM_BIT  = 6;

endpackage

// File: rtl/pic_ocw2_decoder.sv
// Combinational decode of the OCW2 {R, SL, EOI} field into command strobes.
// The sequencer qualifies these with the OCW2 write condition and registers them.
module pic_ocw2_decoder
    import pic_pkg::*;
(
    input  logic [2:0] i_code,
    output logic       o_eoi,
    output logic       o_specific,
    output logic       o_rotate,
    output logic       o_setprio,
    output logic       o_raeoi_set,
    output logic       o_raeoi_clr
);

    always_comb begin
        o_eoi       = 1'b0;
        o_specific  = 1'b0;
        o_rotate    = 1'b0;
        o_setprio   = 1'b0;
        o_raeoi_set = 1'b0;
        o_raeoi_clr = 1'b0;
        case (i_code)
            OCW2_NSEOI:     o_eoi = 1'b1;
            OCW2_SEOI: begin
                o_eoi      = 1'b1;
                o_specific = 1'b1;
            end
            OCW2_ROT_NSEOI: begin
                o_eoi    = 1'b1;
                o_rotate = 1'b1;
            end
            OCW2_ROT_SEOI: begin
                o_eoi      = 1'b1;
                o_specific = 1'b1;
                o_rotate   = 1'b1;
            end
            // set priority is a rotation to a chosen level
            OCW2_SETPRIO: begin
                o_setprio = 1'b1;
                o_rotate  = 1'b1;
            end
            OCW2_RAEOI_SET: o_raeoi_set = 1'b1;
            OCW2_RAEOI_CLR: o_raeoi_clr = 1'b1;
            default:        ;
        endcase
    end

endmodule

// File: rtl/pic_command_sequencer.sv
// Write-side controller: sequences ICW1..ICW4, then decodes OCW1..OCW3 into
// mask, mode bits and one-cycle command pulses for the rest of the controller.
module pic_command_sequencer
    import pic_pkg::*;
#(
    parameter int                NUM_IR      = 8,
    parameter logic [NUM_IR-1:0] IMR_RST_VAL = '0,
    localparam int               LVL_W       = $clog2(NUM_IR)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic              i_a0,
    input  logic [7:0]        i_din,
    output logic              o_init_done,
    output logic [NUM_IR-1:0] o_imr,
    output logic [4:0]        o_vector_base,
    output logic              o_single_mode,
    output logic              o_level_trig,
    output logic [7:0]        o_cascade_cfg,
    output logic              o_aeoi,
    output logic              o_rotate_aeoi,
    output logic              o_eoi_pulse,
    output logic              o_eoi_specific,
    output logic [LVL_W-1:0]  o_eoi_level,
    output logic              o_rotate_pulse,
    output logic              o_setprio_pulse,
    output logic              o_read_isr,
    output logic              o_poll_req,
    output logic              o_special_mask
);

    state_t             r_state;
    logic               r_init_done;
    logic [NUM_IR-1:0]  r_imr;
    logic [4:0]         r_vector_base;
    logic               r_single, r_ltim, r_ic4;
    logic [7:0]         r_cascade_cfg;
    logic               r_aeoi, r_rotate_aeoi;
    logic               r_eoi_pulse, r_eoi_specific, r_rotate_pulse, r_setprio_pulse;
    logic [LVL_W-1:0]   r_eoi_level;
    logic               r_read_isr, r_poll_req, r_special_mask;

    logic w_eoi, w_specific, w_rotate, w_setprio, w_raeoi_set, w_raeoi_clr;
    logic w_icw1;

    assign w_icw1 = i_wr_en && !i_a0 && i_din[ICW1_SEL_BIT];

    pic_ocw2_decoder u_ocw2_dec (
        .i_code      (i_din[7:5]),
        .o_eoi       (w_eoi),
        .o_specific  (w_specific),
        .o_rotate    (w_rotate),
        .o_setprio   (w_setprio),
        .o_raeoi_set (w_raeoi_set),
        .o_raeoi_clr (w_raeoi_clr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_init_done     <= 1'b0;
            r_imr           <= IMR_RST_VAL;
            r_vector_base   <= '0;
            r_single        <= 1'b0;
            r_ltim          <= 1'b0;
            r_ic4           <= 1'b0;
            r_cascade_cfg   <= '0;
            r_aeoi          <= 1'b0;
            r_rotate_aeoi   <= 1'b0;
            r_eoi_pulse     <= 1'b0;
            r_eoi_specific  <= 1'b0;
            r_eoi_level     <= '0;
            r_rotate_pulse  <= 1'b0;
            r_setprio_pulse <= 1'b0;
            r_read_isr      <= 1'b0;
            r_poll_req      <= 1'b0;
            r_special_mask  <= 1'b0;
        end else begin
            r_eoi_pulse     <= 1'b0;
            r_eoi_specific  <= 1'b0;
            r_rotate_pulse  <= 1'b0;
            r_setprio_pulse <= 1'b0;
            r_poll_req      <= 1'b0;

            if (w_icw1) begin
                r_init_done    <= 1'b0;
                r_imr          <= IMR_RST_VAL;
                r_rotate_aeoi  <= 1'b0;
                r_special_mask <= 1'b0;
                r_read_isr     <= 1'b0;
                r_single       <= i_din[ICW1_SNGL_BIT];
                r_ltim         <= i_din[ICW1_LTIM_BIT];
                r_ic4          <= i_din[ICW1_IC4_BIT];
                // no slaves in single mode, so cascade config must not linger
                if (i_din[ICW1_SNGL_BIT])
                    r_cascade_cfg <= '0;
                r_state <= ST_WAIT_ICW2;
            end else if (i_wr_en) begin
                case (r_state)
                    ST_WAIT_ICW2: if (i_a0) begin
                        r_vector_base <= i_din[7:3];
                        if (!r_single) begin
                            r_state <= ST_WAIT_ICW3;
                        end else if (r_ic4) begin
                            r_state <= ST_WAIT_ICW4;
                        end else begin
                            r_state     <= ST_READY;
                            r_init_done <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW3: if (i_a0) begin
                        r_cascade_cfg <= i_din;
                        if (r_ic4) begin
                            r_state <= ST_WAIT_ICW4;
                        end else begin
                            r_state     <= ST_READY;
                            r_init_done <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW4: if (i_a0) begin
                        r_aeoi      <= i_din[ICW4_AEOI_BIT];
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                    ST_READY: begin
                        if (i_a0) begin
                            r_imr <= i_din[NUM_IR-1:0];
                        end else if (!i_din[OCW3_SEL_BIT]) begin
                            r_eoi_level     <= i_din[LVL_W-1:0];
                            r_eoi_pulse     <= w_eoi;
                            r_eoi_specific  <= w_specific;
                            r_rotate_pulse  <= w_rotate;
                            r_setprio_pulse <= w_setprio;
                            if (w_raeoi_set)
                                r_rotate_aeoi <= 1'b1;
                            else if (w_raeoi_clr)
                                r_rotate_aeoi <= 1'b0;
                        end else begin
                            if (i_din[OCW3_RR_BIT])
                                r_read_isr <= i_din[OCW3_RIS_BIT];
                            if (i_din[OCW3_ESMM_BIT])
                                r_special_mask <= i_din[OCW3_SMM_BIT];
                            r_poll_req <= i_din[OCW3_P_BIT];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_init_done     = r_init_done;
    assign o_imr           = r_imr;
    assign o_vector_base   = r_vector_base;
    assign o_single_mode   = r_single;
    assign o_level_trig    = r_ltim;
    assign o_cascade_cfg   = r_cascade_cfg;
    assign o_aeoi          = r_aeoi;
    assign o_rotate_aeoi   = r_rotate_aeoi;
    assign o_eoi_pulse     = r_eoi_pulse;
    assign o_eoi_specific  = r_eoi_specific;
    assign o_eoi_level     = r_eoi_level;
    assign o_rotate_pulse  = r_rotate_pulse;
    assign o_setprio_pulse = r_setprio_pulse;
    assign o_read_isr      = r_read_isr;
    assign o_poll_req      = r_poll_req;
    assign o_special_mask  = r_special_mask;

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Directed bench for pic_command_sequencer: init sequences, OCW decode,
// ICW1 restart and mid-sequence reset, with hand-computed expectations.
module tb_pic_command_sequencer;

    logic       clk = 1'b0;
    logic       reset, wr_en, a0;
    logic [7:0] din;
    logic       init_done, single_mode, level_trig, aeoi, rotate_aeoi;
    logic [7:0] imr, cascade_cfg;
    logic [4:0] vector_base;
    logic       eoi_pulse, eoi_specific, rotate_pulse, setprio_pulse;
    logic [2:0] eoi_level;
    logic       read_isr, poll_req, special_mask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pic_command_sequencer #(.NUM_IR(8), .IMR_RST_VAL(8'h00)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_wr_en         (wr_en),
        .i_a0            (a0),
        .i_din           (din),
        .o_init_done     (init_done),
        .o_imr           (imr),
        .o_vector_base   (vector_base),
        .o_single_mode   (single_mode),
        .o_level_trig    (level_trig),
        .o_cascade_cfg   (cascade_cfg),
        .o_aeoi          (aeoi),
        .o_rotate_aeoi   (rotate_aeoi),
        .o_eoi_pulse     (eoi_pulse),
        .o_eoi_specific  (eoi_specific),
        .o_eoi_level     (eoi_level),
        .o_rotate_pulse  (rotate_pulse),
        .o_setprio_pulse (setprio_pulse),
        .o_read_isr      (read_isr),
        .o_poll_req      (poll_req),
        .o_special_mask  (special_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one write cycle; returns on the falling edge after the sampling edge
    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; a0 = a; din = d;
        @(negedge clk);
        wr_en = 1'b0; a0 = 1'b0; din = 8'h00;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_init_done"}, {31'd0, init_done}, 32'd0);
        chk({pfx, "_imr"}, {24'd0, imr}, 32'h00);
        chk({pfx, "_vector_base"}, {27'd0, vector_base}, 32'd0);
        chk({pfx, "_single"}, {31'd0, single_mode}, 32'd0);
        chk({pfx, "_ltim"}, {31'd0, level_trig}, 32'd0);
        chk({pfx, "_cascade"}, {24'd0, cascade_cfg}, 32'd0);
        chk({pfx, "_aeoi"}, {31'd0, aeoi}, 32'd0);
        chk({pfx, "_raeoi"}, {31'd0, rotate_aeoi}, 32'd0);
        chk({pfx, "_pulses"}, {28'd0, eoi_pulse, rotate_pulse, setprio_pulse, poll_req}, 32'd0);
        chk({pfx, "_eoi_spec_lvl"}, {28'd0, eoi_specific, eoi_level}, 32'd0);
        chk({pfx, "_read_isr"}, {31'd0, read_isr}, 32'd0);
        chk({pfx, "_smm"}, {31'd0, special_mask}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; a0 = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_values("rst");

        // IDLE ignores non-ICW1 writes
        wr(1'b1, 8'hFF);
        chk("idle_imr", {24'd0, imr}, 32'h00);
        chk("idle_vector", {27'd0, vector_base}, 32'd0);

        // 1: single mode with ICW4
        wr(1'b0, 8'h13);
        chk("t1_single", {31'd0, single_mode}, 32'd1);
        chk("t1_ltim", {31'd0, level_trig}, 32'd0);
        wr(1'b0, 8'h02);        // ignored in WAIT_ICW2
        chk("t1_ign_vector", {27'd0, vector_base}, 32'd0);
        wr(1'b1, 8'h40);
        chk("t1_vector", {27'd0, vector_base}, 32'h08);
        chk("t1_not_done_2", {31'd0, init_done}, 32'd0);
        wr(1'b1, 8'h03);
        chk("t1_done", {31'd0, init_done}, 32'd1);
        chk("t1_aeoi", {31'd0, aeoi}, 32'd1);
        chk("t1_cascade", {24'd0, cascade_cfg}, 32'd0);

        // 2: cascade mode with ICW3 and ICW4, level-triggered
        wr(1'b0, 8'h19);
        chk("t2_done_clr", {31'd0, init_done}, 32'd0);
        chk("t2_ltim", {31'd0, level_trig}, 32'd1);
        wr(1'b1, 8'h20);
        chk("t2_vector", {27'd0, vector_base}, 32'h04);
        chk("t2_not_done_2", {31'd0, init_done}, 32'd0);
        wr(1'b1, 8'h04);
        chk("t2_cascade", {24'd0, cascade_cfg}, 32'h04);
        chk("t2_not_done_3", {31'd0, init_done}, 32'd0);
        wr(1'b1, 8'h01);
        chk("t2_done", {31'd0, init_done}, 32'd1);
        chk("t2_aeoi", {31'd0, aeoi}, 32'd0);

        // 3: OCW1 and OCW2
        wr(1'b1, 8'hA5);
        chk("t3_imr", {24'd0, imr}, 32'hA5);
        wr(1'b0, 8'h63);
        chk("t3_seoi", {29'd0, eoi_pulse, eoi_specific, rotate_pulse}, 32'b110);
        chk("t3_seoi_lvl", {29'd0, eoi_level}, 32'd3);
        idle_cycle();
        chk("t3_seoi_gone", {31'd0, eoi_pulse}, 32'd0);
        wr(1'b0, 8'hC5);
        chk("t3_setprio", {30'd0, setprio_pulse, eoi_pulse}, 32'b10);
        chk("t3_setprio_lvl", {29'd0, eoi_level}, 32'd5);
        idle_cycle();
        chk("t3_setprio_gone", {31'd0, setprio_pulse}, 32'd0);
        wr(1'b0, 8'h20);
        chk("t3_nseoi", {29'd0, eoi_pulse, eoi_specific, rotate_pulse}, 32'b100);
        wr(1'b0, 8'hA2);
        chk("t3_rot_nseoi", {29'd0, eoi_pulse, eoi_specific, rotate_pulse}, 32'b101);
        chk("t3_rot_lvl", {29'd0, eoi_level}, 32'd2);
        wr(1'b0, 8'h80);
        chk("t3_raeoi_set", {31'd0, rotate_aeoi}, 32'd1);
        chk("t3_raeoi_nopulse", {29'd0, eoi_pulse, rotate_pulse, setprio_pulse}, 32'd0);
        wr(1'b0, 8'h40);
        chk("t3_nop_raeoi", {31'd0, rotate_aeoi}, 32'd1);
        chk("t3_nop_pulse", {29'd0, eoi_pulse, rotate_pulse, setprio_pulse}, 32'd0);
        wr(1'b0, 8'h00);
        chk("t3_raeoi_clr", {31'd0, rotate_aeoi}, 32'd0);
        chk("t3_imr_kept", {24'd0, imr}, 32'hA5);

        // 4: OCW3
        wr(1'b0, 8'h0B);
        chk("t4_read_isr", {31'd0, read_isr}, 32'd1);
        wr(1'b0, 8'h0C);
        chk("t4_poll", {31'd0, poll_req}, 32'd1);
        chk("t4_read_isr_kept", {31'd0, read_isr}, 32'd1);
        idle_cycle();
        chk("t4_poll_gone", {31'd0, poll_req}, 32'd0);
        wr(1'b0, 8'h68);
        chk("t4_smm", {31'd0, special_mask}, 32'd1);
        wr(1'b0, 8'h28);        // SMM without ESMM leaves the mode alone
        chk("t4_smm_kept", {31'd0, special_mask}, 32'd1);
        wr(1'b0, 8'h0A);
        chk("t4_read_irr", {31'd0, read_isr}, 32'd0);

        // 5: ICW1 restart from WAIT_ICW3
        wr(1'b0, 8'h0B);
        wr(1'b0, 8'h11);
        chk("t5_imr_clr", {24'd0, imr}, 32'h00);
        chk("t5_mode_clr", {29'd0, read_isr, special_mask, rotate_aeoi}, 32'd0);
        wr(1'b1, 8'h30);
        chk("t5_vector_a", {27'd0, vector_base}, 32'h06);
        wr(1'b0, 8'h11);        // now in WAIT_ICW3
        chk("t5_done_clr", {31'd0, init_done}, 32'd0);
        chk("t5_imr_rst", {24'd0, imr}, 32'h00);
        wr(1'b1, 8'h48);        // accepted as ICW2 again
        chk("t5_vector_b", {27'd0, vector_base}, 32'h09);
        chk("t5_cascade_kept", {24'd0, cascade_cfg}, 32'h04);
        wr(1'b1, 8'h02);
        chk("t5_cascade", {24'd0, cascade_cfg}, 32'h02);
        chk("t5_not_done", {31'd0, init_done}, 32'd0);
        wr(1'b1, 8'h02);
        chk("t5_done", {31'd0, init_done}, 32'd1);
        chk("t5_aeoi", {31'd0, aeoi}, 32'd1);

        // 6: reset during WAIT_ICW4 with a write present
        wr(1'b0, 8'h13);
        wr(1'b1, 8'hF8);
        @(negedge clk);
        reset = 1'b1; wr_en = 1'b1; a0 = 1'b1; din = 8'h03;
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0; a0 = 1'b0; din = 8'h00;
        chk_reset_values("t6");
        wr(1'b1, 8'h02);        // IDLE: ignored, so not taken as ICW4
        chk("t6_idle_aeoi", {31'd0, aeoi}, 32'd0);
        chk("t6_idle_done", {31'd0, init_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
